// File: rtl/chan_pkt_pkg.sv
// rtl/chan_pkt_pkg.sv - channel packet header fields and FIFO-side state encodings
package chan_pkt_pkg;

    localparam int HDR_OVERRUN      = 31;
    localparam int HDR_STARTOFBURST = 28;
    localparam int HDR_ENDOFBURST   = 27;
    localparam int HDR_RSSI_FLAG    = 26;
    localparam int HDR_MF_FLAG      = 25;
    localparam int HDR_CHAN_MSB     = 20;
    localparam int HDR_CHAN_LSB     = 16;
    localparam int HDR_RSSI_MSB     = 15;
    localparam int HDR_RSSI_LSB     = 9;
    localparam int HDR_PAYLOAD_MSB  = 8;
    localparam int HDR_PAYLOAD_LSB  = 2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR     = 3'd1,
        ST_TS      = 3'd2,
        ST_FIRST   = 3'd3,
        ST_COLLECT = 3'd4,
        ST_PAD     = 3'd5
    } chan_state_e;

    function automatic logic [6:0] rssi_sat(input logic [31:0] rssi);
        return (rssi > 32'd127) ? 7'd127 : rssi[6:0];
    endfunction

endpackage

// File: rtl/chan_fifo_writer_if.sv
// rtl/chan_fifo_writer_if.sv - write port into the per-channel RX FIFO
interface chan_fifo_writer_if;
    logic [8:0]  fifo_space;
    logic        wrreq;
    logic [31:0] fifodata;
    logic        pkt_done;

    modport master (input fifo_space, output wrreq, output fifodata, output pkt_done);
    modport slave  (output fifo_space, input wrreq, input fifodata, input pkt_done);
endinterface

// File: rtl/chan_header_pack.sv
// rtl/chan_header_pack.sv - combinational packet header assembly (RSSI tag under RX_RSSI_TAG_EN)
module chan_header_pack
    import chan_pkt_pkg::*;
(
    input  logic [6:0]  payload,
    input  logic [4:0]  chan,
    input  logic        start_of_burst,
    input  logic        overrun,
    input  logic [31:0] rssi,
    output logic [31:0] header
);

`ifndef RX_RSSI_TAG_EN
    logic unused_rssi;
    assign unused_rssi = ^rssi;
`endif

    always_comb begin
        header = '0;
        header[HDR_PAYLOAD_MSB:HDR_PAYLOAD_LSB] = payload;
        header[HDR_CHAN_MSB:HDR_CHAN_LSB]       = chan;
        header[HDR_STARTOFBURST]                = start_of_burst;
        header[HDR_OVERRUN]                     = overrun;
`ifdef RX_RSSI_TAG_EN
        header[HDR_RSSI_MSB:HDR_RSSI_LSB]       = rssi_sat(rssi);
`else
        header[HDR_RSSI_MSB:HDR_RSSI_LSB]       = 7'd0;
`endif
    end

endmodule

// File: rtl/chan_fifo_writer.sv
// rtl/chan_fifo_writer.sv - frames rx samples into header/timestamp/payload packets; RX_RSSI_TAG_EN tags header with RSSI
module chan_fifo_writer
    import chan_pkt_pkg::*;
#(
    parameter int PKT_SAMPLES = 126,
    parameter int CHANNEL     = 0
) (
    input  logic                      rx_clock,
    input  logic                      reset,
    input  logic                      rx_enable,
    input  logic                      rx_strobe,
    input  logic [15:0]               rx_i,
    input  logic [15:0]               rx_q,
    input  logic [31:0]               timestamp_clock,
    input  logic [31:0]               rssi,
    chan_fifo_writer_if.master        fifo,
    output logic                      overrun,
    output logic [14:0]               debug
);

    localparam logic [6:0] PKT_LEN      = 7'(PKT_SAMPLES);
    localparam logic [8:0] SPACE_NEEDED = 9'(PKT_SAMPLES + 2);
    localparam logic [4:0] CHAN_ID      = 5'(CHANNEL);

    chan_state_e state_q, state_d;
    logic [6:0]  count_q, count_d;
    logic        burst_active_q, burst_active_d;
    logic        ovr_pend_q, ovr_pend_d;
    logic [31:0] sample_q, sample_d;
    logic [31:0] ts_q, ts_d;

    logic        wrreq_c, pkt_done_c, overrun_c;
    logic [31:0] fifodata_c;
    logic [31:0] header;

    chan_header_pack u_header_pack (
        .payload        (PKT_LEN),
        .chan           (CHAN_ID),
        .start_of_burst (!burst_active_q),
        .overrun        (ovr_pend_q),
        .rssi           (rssi),
        .header         (header)
    );

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        burst_active_d = burst_active_q;
        ovr_pend_d     = ovr_pend_q;
        sample_d       = sample_q;
        ts_d           = ts_q;
        wrreq_c        = 1'b0;
        pkt_done_c     = 1'b0;
        overrun_c      = 1'b0;
        fifodata_c     = 32'd0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_enable) begin
                    burst_active_d = 1'b0;
                end else if (rx_strobe) begin
                    // Room for the whole packet is checked up front so packets are never truncated.
                    if (fifo.fifo_space >= SPACE_NEEDED) begin
                        sample_d = {rx_q, rx_i};
                        ts_d     = timestamp_clock;
                        state_d  = ST_HDR;
                    end else begin
                        overrun_c      = 1'b1;
                        ovr_pend_d     = 1'b1;
                        burst_active_d = 1'b1;
                    end
                end
            end
            ST_HDR: begin
                wrreq_c        = 1'b1;
                fifodata_c     = header;
                burst_active_d = 1'b1;
                ovr_pend_d     = 1'b0;
                state_d        = ST_TS;
            end
            ST_TS: begin
                wrreq_c    = 1'b1;
                fifodata_c = ts_q;
                state_d    = ST_FIRST;
            end
            ST_FIRST: begin
                wrreq_c    = 1'b1;
                fifodata_c = sample_q;
                count_d    = 7'd1;
                if (PKT_LEN == 7'd1) begin
                    pkt_done_c = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    state_d    = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (!rx_enable) begin
                    state_d = ST_PAD;
                end else if (rx_strobe) begin
                    wrreq_c    = 1'b1;
                    fifodata_c = {rx_q, rx_i};
                    count_d    = count_q + 7'd1;
                    if (count_d == PKT_LEN) begin
                        pkt_done_c = 1'b1;
                        state_d    = ST_IDLE;
                    end
                end
            end
            ST_PAD: begin
                wrreq_c    = 1'b1;
                fifodata_c = 32'd0;
                count_d    = count_q + 7'd1;
                if (count_d == PKT_LEN) begin
                    pkt_done_c     = 1'b1;
                    burst_active_d = 1'b0;
                    state_d        = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Nothing escapes to the FIFO while reset is held.
        if (reset) begin
            wrreq_c    = 1'b0;
            pkt_done_c = 1'b0;
            overrun_c  = 1'b0;
            fifodata_c = 32'd0;
        end
    end

    always_ff @(posedge rx_clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= 7'd0;
            burst_active_q <= 1'b0;
            ovr_pend_q     <= 1'b0;
            sample_q       <= 32'd0;
            ts_q           <= 32'd0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            burst_active_q <= burst_active_d;
            ovr_pend_q     <= ovr_pend_d;
            sample_q       <= sample_d;
            ts_q           <= ts_d;
        end
    end

    assign fifo.wrreq    = wrreq_c;
    assign fifo.fifodata = fifodata_c;
    assign fifo.pkt_done = pkt_done_c;
    assign overrun       = overrun_c;
    assign debug         = {6'd0, wrreq_c, pkt_done_c, overrun_c, 3'(state_q),
                            rx_enable, rx_strobe, rx_clock};

endmodule

// File: tb/tb_chan_fifo_writer.sv
// tb/tb_chan_fifo_writer.sv - packet-level model and directed vectors for chan_fifo_writer
module tb_chan_fifo_writer;

    localparam int PKT = 4;
    localparam int CH  = 3;

    logic        rx_clock = 1'b0;
    logic        reset;
    logic        rx_enable;
    logic        rx_strobe;
    logic [15:0] rx_i, rx_q;
    logic [31:0] ts;
    logic [31:0] rssi;
    logic        overrun;
    logic [14:0] debug;

    chan_fifo_writer_if fif ();

    chan_fifo_writer #(.PKT_SAMPLES(PKT), .CHANNEL(CH)) dut (
        .rx_clock        (rx_clock),
        .reset           (reset),
        .rx_enable       (rx_enable),
        .rx_strobe       (rx_strobe),
        .rx_i            (rx_i),
        .rx_q            (rx_q),
        .timestamp_clock (ts),
        .rssi            (rssi),
        .fifo            (fif),
        .overrun         (overrun),
        .debug           (debug)
    );

    always #5 rx_clock = ~rx_clock;

    int checks = 0;
    int errors = 0;

    // Expected FIFO words, {pkt_done, data}, in write order.
    logic [32:0] exp_q[$];
    logic        exp_ovr_now = 1'b0;
    bit          m_in_pkt = 0;
    bit          m_burst  = 0;
    bit          m_ovr    = 0;
    int          m_n      = 0;
    logic [31:0] last_hdr = 32'd0;
    int          dut_ovr_cnt = 0;
    int          words_in_pkt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] model_hdr(input bit sob, input bit ovr, input logic [31:0] r);
        logic [31:0] h;
        h = 32'd0;
        h[8:2]   = 7'(PKT);
        h[20:16] = 5'(CH);
        h[28]    = sob;
        h[31]    = ovr;
`ifdef RX_RSSI_TAG_EN
        h[15:9]  = (r > 32'd127) ? 7'd127 : r[6:0];
`else
        h[15:9]  = (r == r) ? 7'd0 : 7'd1;
`endif
        return h;
    endfunction

    task automatic model_strobe(input logic [15:0] i, input logic [15:0] q,
                                input logic [31:0] t, input int sp);
        if (!rx_enable) return;
        if (!m_in_pkt) begin
            if (sp >= PKT + 2) begin
                last_hdr = model_hdr(!m_burst, m_ovr, rssi);
                exp_q.push_back({1'b0, last_hdr});
                exp_q.push_back({1'b0, t});
                exp_q.push_back({PKT == 1, q, i});
                m_burst  = 1;
                m_ovr    = 0;
                m_n      = 1;
                m_in_pkt = (PKT > 1);
            end else begin
                exp_ovr_now = 1'b1;
                m_ovr   = 1;
                m_burst = 1;
            end
        end else begin
            m_n++;
            exp_q.push_back({m_n == PKT, q, i});
            if (m_n == PKT) m_in_pkt = 0;
        end
    endtask

    task automatic tick;
        @(posedge rx_clock);
        #1;
    endtask

    task automatic strobe(input logic [15:0] i, input logic [15:0] q,
                          input logic [31:0] t, input int sp);
        rx_i = i; rx_q = q; ts = t; fif.fifo_space = 9'(sp);
        rx_strobe = 1'b1;
        model_strobe(i, q, t, sp);
        tick;
        rx_strobe = 1'b0;
        exp_ovr_now = 1'b0;
        repeat (3) tick;
    endtask

    task automatic drop_enable;
        rx_enable = 1'b0;
        if (m_in_pkt) begin
            for (int k = m_n + 1; k <= PKT; k++) exp_q.push_back({k == PKT, 32'd0});
            m_in_pkt = 0;
        end
        m_burst = 0;
        repeat (PKT + 2) tick;
    endtask

    // Compare process: every DUT write must match the next modelled word.
    always @(negedge rx_clock) begin
        check("overrun", 32'(overrun), 32'(exp_ovr_now));
        if (overrun) dut_ovr_cnt++;
        if (reset) begin
            words_in_pkt = 0;
            check("wrreq_in_reset", 32'(fif.wrreq), 32'd0);
        end else if (fif.wrreq) begin
            words_in_pkt++;
            if (exp_q.size() == 0) begin
                check("spurious_wrreq", 32'(fif.wrreq), 32'd0);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("fifodata", fif.fifodata, e[31:0]);
                check("pkt_done", 32'(fif.pkt_done), 32'(e[32]));
            end
            if (fif.pkt_done) begin
                check("pkt_len", 32'(words_in_pkt), 32'(PKT + 2));
                words_in_pkt = 0;
            end
        end else begin
            check("pkt_done_no_wr", 32'(fif.pkt_done), 32'd0);
        end
    end

    initial begin
        reset = 1'b1; rx_enable = 1'b0; rx_strobe = 1'b0;
        rx_i = '0; rx_q = '0; ts = '0; rssi = '0; fif.fifo_space = 9'd511;
        repeat (2) tick;
        @(negedge rx_clock);
        check("rst_wrreq",    32'(fif.wrreq),    32'd0);
        check("rst_pkt_done", 32'(fif.pkt_done), 32'd0);
        check("rst_overrun",  32'(overrun),      32'd0);
        check("rst_fifodata", fif.fifodata,      32'd0);
        check("rst_state",    32'(debug[5:3]),   32'd0);
        tick;
        reset = 1'b0;
        rx_enable = 1'b1;
        tick;

        // First packet by hand to pin latency: header next cycle, first sample three cycles on.
        rx_i = 16'd1; rx_q = 16'h10; ts = 32'd100; rx_strobe = 1'b1;
        model_strobe(16'd1, 16'h10, 32'd100, 511);
        check("model_hdr_first", last_hdr, 32'h10030010);
        tick;
        rx_strobe = 1'b0;
        @(negedge rx_clock);
        check("hdr_latency_wr",  32'(fif.wrreq), 32'd1);
        check("hdr_latency_dat", fif.fifodata,   32'h10030010);
        tick; tick;
        @(negedge rx_clock);
        check("first_latency", fif.fifodata, 32'h00100001);
        tick;
        for (int k = 2; k <= 4; k++) strobe(16'(k), 16'(16'h10 + k - 1), 32'd100 + 32'(k), 511);

        // Two back-to-back packets within the burst.
        for (int k = 5; k <= 12; k++) begin
            strobe(16'(k), 16'(16'h20 + k), 32'd200 + 32'(k), 511);
            if (k == 5 || k == 9) check("mid_burst_hdr", last_hdr, 32'h00030010);
        end

        // Not enough space: drop, then flag overrun in the next header only.
        strobe(16'hAAAA, 16'hBBBB, 32'd300, 5);
        check("ovr_count", 32'(dut_ovr_cnt), 32'd1);
        strobe(16'd21, 16'd31, 32'd301, 511);
        check("ovr_hdr", last_hdr, 32'h80030010);
        for (int k = 0; k < 3; k++) strobe(16'(22 + k), 16'(32 + k), 32'd302, 511);
        strobe(16'd40, 16'd50, 32'd310, 511);
        check("ovr_cleared_hdr", last_hdr, 32'h00030010);
        for (int k = 0; k < 3; k++) strobe(16'(41 + k), 16'(51 + k), 32'd311, 511);

        // Enable falls after two samples: padding, then a new burst.
        strobe(16'd60, 16'd70, 32'd400, 511);
        strobe(16'd61, 16'd71, 32'd404, 511);
        drop_enable;
        rx_enable = 1'b1;
        tick;
        strobe(16'd62, 16'd72, 32'd500, 511);
        check("new_burst_hdr", last_hdr, 32'h10030010);
        for (int k = 0; k < 3; k++) strobe(16'(63 + k), 16'(73 + k), 32'd501, 511);

        // Reset mid-packet.
        strobe(16'd80, 16'd90, 32'd600, 511);
        strobe(16'd81, 16'd91, 32'd604, 511);
        reset = 1'b1;
        exp_q.delete();
        m_in_pkt = 0; m_burst = 0; m_ovr = 0;
        tick;
        reset = 1'b0;
        @(negedge rx_clock);
        check("post_rst_wrreq", 32'(fif.wrreq), 32'd0);
        check("post_rst_state", 32'(debug[5:3]), 32'd0);
        tick;

        // RSSI tag, saturated and small.
        rssi = 32'd300;
        strobe(16'd100, 16'd110, 32'd700, 511);
`ifdef RX_RSSI_TAG_EN
        check("rssi_sat_hdr", last_hdr, 32'h1003FE10);
`else
        check("rssi_sat_hdr", last_hdr, 32'h10030010);
`endif
        for (int k = 0; k < 3; k++) strobe(16'(101 + k), 16'(111 + k), 32'd701, 511);
        rssi = 32'd5;
        strobe(16'd120, 16'd130, 32'd800, 511);
`ifdef RX_RSSI_TAG_EN
        check("rssi_small_hdr", last_hdr, 32'h00030A10);
`else
        check("rssi_small_hdr", last_hdr, 32'h00030010);
`endif
        for (int k = 0; k < 3; k++) strobe(16'(121 + k), 16'(131 + k), 32'd801, 511);

        // Strobe while disabled is ignored.
        rx_enable = 1'b0;
        tick;
        strobe(16'hDEAD, 16'hBEEF, 32'd900, 0);

        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick;
        check("drain", 32'(exp_q.size()), 32'd0);
        check("ovr_total", 32'(dut_ovr_cnt), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
